// File: rtl/stall_ctrl.sv
// Tuse/Tnew hazard controller for the five-stage MIPS pipeline: tracks the E and M
// writer records, stalls F/D on conflicts. Optional stall counter under STALL_CTRL_CNT_EN.
module stall_ctrl #(
    parameter int TNEW_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_j,
    input  logic              d_r,
    input  logic              d_i,
    input  logic              d_ld,
    input  logic              d_st,
    input  logic              d_jal,
    input  logic [4:0]        d_rs,
    input  logic [4:0]        d_rt,
    input  logic [4:0]        d_rd,
    output logic              stall,
    output logic [4:0]        e_wreg,
    output logic [TNEW_W-1:0] e_tnew,
    output logic [4:0]        m_wreg,
    output logic [TNEW_W-1:0] m_tnew
`ifdef STALL_CTRL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    // Tuse is at most 3, so compare in a width that holds both Tuse and Tnew.
    localparam int CW = (TNEW_W > 2) ? TNEW_W : 2;

    logic [1:0]        tuse_rs;
    logic [1:0]        tuse_rt;
    logic [4:0]        d_wreg;
    logic [TNEW_W-1:0] d_tnew;
    logic [CW-1:0]     tuse_rs_x;
    logic [CW-1:0]     tuse_rt_x;
    logic [CW-1:0]     e_tnew_x;
    logic [CW-1:0]     m_tnew_x;

    always_comb begin
        tuse_rs = 2'd3;
        if (d_j)
            tuse_rs = 2'd0;
        else if (d_r | d_i | d_ld | d_st)
            tuse_rs = 2'd1;

        tuse_rt = 2'd3;
        if (d_j)
            tuse_rt = 2'd0;
        else if (d_r)
            tuse_rt = 2'd1;
        else if (d_st)
            tuse_rt = 2'd2;

        d_wreg = 5'd0;
        if (d_ld)
            d_wreg = d_rt;
        else if (d_i)
            d_wreg = d_rt;
        else if (d_r)
            d_wreg = d_rd;
        else if (d_jal)
            d_wreg = d_rd;

        d_tnew = '0;
        if (d_ld)
            d_tnew = TNEW_W'(2);
        else if (d_r | d_i)
            d_tnew = TNEW_W'(1);
    end

    assign tuse_rs_x = CW'(tuse_rs);
    assign tuse_rt_x = CW'(tuse_rt);
    assign e_tnew_x  = CW'(e_tnew);
    assign m_tnew_x  = CW'(m_tnew);

    function automatic logic hazard(input logic [4:0]    wreg,
                                    input logic [CW-1:0] tnew,
                                    input logic [4:0]    src,
                                    input logic [CW-1:0] tuse);
        return (wreg != 5'd0) && (wreg == src) && (tuse < tnew);
    endfunction

    assign stall = hazard(e_wreg, e_tnew_x, d_rs, tuse_rs_x)
                 | hazard(e_wreg, e_tnew_x, d_rt, tuse_rt_x)
                 | hazard(m_wreg, m_tnew_x, d_rs, tuse_rs_x)
                 | hazard(m_wreg, m_tnew_x, d_rt, tuse_rt_x);

    // A stalled D instruction stays in F/D, so E receives a bubble instead of it.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_wreg <= 5'd0;
            e_tnew <= '0;
            m_wreg <= 5'd0;
            m_tnew <= '0;
        end else begin
            m_wreg <= e_wreg;
            m_tnew <= (e_tnew == '0) ? '0 : e_tnew - TNEW_W'(1);
            if (stall) begin
                e_wreg <= 5'd0;
                e_tnew <= '0;
            end else begin
                e_wreg <= d_wreg;
                e_tnew <= d_tnew;
            end
        end
    end

`ifdef STALL_CTRL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= 32'd0;
        else if (stall)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule
